instr_fetch_unit: RTL and testbench

Fetch front-end for the multicycle RISC-V core. It is the initiator side of the instruction ROM interface. It drives a 14-bit byte address to the ROM, whose read data is registered and appears one clock later. It captures the returned word and presents it to the core through a valid/ready handshake. It also handles branch/jump redirects, discards in-flight data, flags misaligned targets and counts retired fetches.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch front-end: ROM initiator, valid/ready presenter, redirects, fault flag
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_err,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_ISSUE   = 3'd0,
    S_CAPTURE = 3'd1,
    S_PRESENT = 3'd2,
    S_FAULT   = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        instr_err_q, instr_err_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] pc_plus4;
  logic        handshake;

  assign pc_plus4    = pc_q + 32'd4;
  assign handshake   = instr_valid_q & instr_ready;

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_err   = instr_err_q;
  assign fetch_count = fetch_count_q;

  // Next-state, ROM address and presented-instruction logic; a redirect overrides everything but the accept count.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    instr_err_d   = instr_err_q;
    fetch_count_d = fetch_count_q;
    rom_addr      = pc_q[ADDR_W-1:0];

    case (state_q)
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        instr_d       = rom_data;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
        state_d       = S_PRESENT;
      end
      S_PRESENT: begin
        // Issue the next address in the accept cycle so the ISSUE cycle is skipped.
        if (handshake) begin
          pc_d          = pc_plus4;
          rom_addr      = pc_plus4[ADDR_W-1:0];
          instr_valid_d = 1'b0;
          state_d       = S_CAPTURE;
        end
      end
      S_FAULT: begin
        if (handshake) begin
          instr_valid_d = 1'b0;
          instr_err_d   = 1'b0;
          state_d       = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase

    // An instruction accepted in the same cycle as a redirect still counts.
    if (handshake) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rom_addr = redirect_pc[ADDR_W-1:0];
      if (redirect_pc[1:0] != 2'b00) begin
        // Misaligned target: present a fault record instead of fetching.
        state_d       = S_FAULT;
        instr_valid_d = 1'b1;
        instr_err_d   = 1'b1;
        instr_d       = 32'd0;
        instr_pc_d    = redirect_pc;
      end else begin
        state_d       = S_CAPTURE;
        instr_valid_d = 1'b0;
        instr_err_d   = 1'b0;
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ISSUE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      instr_err_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_err_q   <= instr_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit with ROM model and reference model
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  // Reference model: next PC to present, cycles until it is visible, mode (0 fetch, 1 fault, 2 halted).
  logic [31:0] m_pc;
  logic [31:0] m_count;
  int          m_wait;
  int          m_mode;

  instr_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(14)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_err     (instr_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ROM: word is 0xA000_0000 | byte address, zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rom_data <= 32'd0;
    else        rom_data <= 32'hA000_0000 | {18'd0, rom_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic m_valid();
    return (m_mode == 0 && m_wait == 0) || m_mode == 1;
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 | {18'd0, a[13:0]};
  endfunction

  task automatic model_reset();
    m_pc    = 32'd0;
    m_count = 32'd0;
    m_wait  = 2;
    m_mode  = 0;
  endtask

  // Apply inputs, then at the falling edge compare every visible output against the model.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc);
    logic [31:0] exp_addr;
    instr_ready    = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    if (rv)                    exp_addr = rpc;
    else if (m_valid() && m_mode == 0 && r) exp_addr = m_pc + 32'd4;
    else                       exp_addr = m_pc;
    chk("rom_addr", {18'd0, rom_addr}, {18'd0, exp_addr[13:0]});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid()});
    chk("instr_err", {31'd0, instr_err}, {31'd0, m_mode == 1});
    chk("fetch_count", fetch_count, m_count);
    if (m_valid()) begin
      chk("instr_pc", instr_pc, m_pc);
      chk("instr", instr, (m_mode == 1) ? 32'd0 : rom_word(m_pc));
    end
  endtask

  // Advance through the rising edge and step the model with the inputs that were applied.
  task automatic tick();
    logic hs;
    @(posedge clk);
    hs = m_valid() & instr_ready;
    if (hs) m_count = m_count + 32'd1;
    if (redirect_valid) begin
      m_pc   = redirect_pc;
      m_mode = (redirect_pc[1:0] != 2'b00) ? 1 : 0;
      m_wait = 1;
    end else if (m_mode == 0) begin
      if (m_wait > 0) m_wait--;
      else if (hs) begin
        m_pc   = m_pc + 32'd4;
        m_wait = 1;
      end
    end else if (m_mode == 1 && hs) begin
      m_mode = 2;
    end
    #1;
  endtask

  task automatic reset_checks();
    chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst instr_pc", instr_pc, 32'd0);
    chk("rst instr_err", {31'd0, instr_err}, 32'd0);
    chk("rst fetch_count", fetch_count, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;

    // Startup with ready tied high.
    drive(1, 0, 0); chk("startup rom_addr", {18'd0, rom_addr}, 32'd0); tick();
    drive(1, 0, 0); tick();
    drive(1, 0, 0);
    chk("first valid", {31'd0, instr_valid}, 32'd1);
    chk("first instr", instr, 32'hA000_0000);
    chk("first pc", instr_pc, 32'd0);
    tick();
    drive(1, 0, 0); tick();
    drive(1, 0, 0); chk("second instr", instr, 32'hA000_0004); tick();
    drive(0, 0, 0); chk("count after two", fetch_count, 32'd2); tick();

    // Backpressure for five cycles on the word at 0x8.
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0);
      chk("hold instr", instr, 32'hA000_0008);
      chk("hold rom_addr", {18'd0, rom_addr}, 32'h8);
      chk("hold count", fetch_count, 32'd2);
      tick();
    end
    drive(1, 0, 0); tick();

    // Redirect during CAPTURE discards the in-flight word.
    drive(0, 1, 32'h100); tick();
    drive(0, 0, 0); chk("redir gap", {31'd0, instr_valid}, 32'd0); tick();
    drive(0, 0, 0);
    chk("redir instr", instr, 32'hA000_0100);
    chk("redir pc", instr_pc, 32'h100);
    tick();

    // Redirect together with a handshake in PRESENT.
    drive(1, 1, 32'h200); tick();
    drive(0, 0, 0); chk("redir+hs count", fetch_count, 32'd4); tick();
    drive(0, 0, 0); chk("redir+hs pc", instr_pc, 32'h200); tick();

    // Misaligned redirect, fault acceptance, halt, then recovery.
    drive(0, 1, 32'h102); tick();
    drive(0, 0, 0);
    chk("fault err", {31'd0, instr_err}, 32'd1);
    chk("fault instr", instr, 32'd0);
    chk("fault pc", instr_pc, 32'h102);
    tick();
    drive(1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0); chk("halt valid", {31'd0, instr_valid}, 32'd0); tick();
    end
    drive(1, 1, 32'h40); tick();
    drive(0, 0, 0); tick();
    drive(0, 0, 0); chk("recover instr", instr, 32'hA000_0040); tick();

    // Asynchronous reset while presenting.
    instr_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0); tick(); end
    drive(0, 0, 0); chk("restart pc", instr_pc, 32'd0); tick();

    // PC wrap from the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC); tick();
    drive(0, 0, 0); tick();
    drive(1, 0, 0); chk("top instr", instr, 32'hA000_3FFC); tick();
    drive(0, 0, 0); tick();
    drive(0, 0, 0); chk("wrap pc", instr_pc, 32'd0); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
      drive(r, rv, rpc);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
